lnk_rq_arbiter: RTL and testbench

- Sits directly downstream of the per-lane lane masters. It collects their RQI requests and arbitrates round-robin between them.
- It hands one request at a time to the link request executor, then returns the per-lane RQR done/error response that the lane master consumes as rqDone.
- Replaces the tie-high M_GRANT used in single-lane builds, enabling multi-lane links.

---
 rtl/lnk_rq_pkg.sv | 32 +++
 rtl/lnk_rr_pick.sv | 27 ++
 rtl/lnk_rq_arbiter.sv | 151 +++++++++++++++
 tb/tb_lnk_rq_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lnk_rq_pkg.sv
// Shared link-request definitions: request codes, response bit positions, arbiter state encoding.
// Pure declarations; no logic, no latency, no flow control.
package lnk_rq_pkg;

    localparam int SZ_RQCODE = 5;

    localparam logic [SZ_RQCODE-1:0] RQC_NOP     = 5'h00;
    localparam logic [SZ_RQCODE-1:0] RQC_L2R     = 5'h01;
    localparam logic [SZ_RQCODE-1:0] RQC_L2D     = 5'h02;
    localparam logic [SZ_RQCODE-1:0] RQC_PCSRST0 = 5'h03;
    localparam logic [SZ_RQCODE-1:0] RQC_PCSRST1 = 5'h04;
    localparam logic [SZ_RQCODE-1:0] RQC_LNKUP   = 5'h05;
    localparam logic [SZ_RQCODE-1:0] RQC_LNKDN   = 5'h06;
    localparam logic [SZ_RQCODE-1:0] RQC_EQTRAIN = 5'h07;

    localparam int RQR_DONE = 0;
    localparam int RQR_ERR  = 1;

    typedef enum logic [1:0] {
        AIDLE = 2'd0,
        AEXEC = 2'd1,
        ARESP = 2'd2,
        AREL  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic withdrawn;
        logic err;
        logic abort;
    } xact_flags_t;

endpackage

// File: rtl/lnk_rr_pick.sv
// Round-robin selector: first eligible lane strictly after pointer, wrapping; purely combinational.
// Zero latency; no flow control, found=0 when nothing is eligible.
module lnk_rr_pick #(
    parameter int NLANES = 4,
    parameter int LW     = 2
) (
    input  logic [NLANES-1:0] eligible,
    input  logic [LW-1:0]     pointer,
    output logic              found,
    output logic [LW-1:0]     index
);

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        index = '0;
        for (int i = 1; i <= NLANES; i++) begin
            cand = (int'(pointer) + i) % NLANES;
            if (!found && eligible[cand]) begin
                found = 1'b1;
                index = LW'(cand);
            end
        end
    end

endmodule

// File: rtl/lnk_rq_arbiter.sv
// Round-robin arbiter handing lane requests to the link request executor; grant 1 cycle after request.
// Executor backpressure via X_VALID held until X_DONE or timeout abort; lanes released when they drop M_REQUEST.
module lnk_rq_arbiter #(
    parameter int              NLANES    = 4,
    parameter int              LW        = 2,
    parameter int              SZ_RQCODE = 5,
    parameter int              TMO_W     = 16,
    parameter logic [TMO_W-1:0] TMO_CYC  = 16'd50000
) (
    input  logic                              CTRL_CLK,
    input  logic                              CTRL_SRST,
    input  logic [NLANES-1:0]                 M_REQUEST,
    input  logic [NLANES*(SZ_RQCODE+1)-1:0]   RQI_BUS,
    output logic [NLANES-1:0]                 M_GRANT,
    output logic [NLANES*2-1:0]               RQR_BUS,
    output logic                              X_VALID,
    output logic [SZ_RQCODE-1:0]              X_CODE,
    output logic [LW-1:0]                     X_LANE,
    input  logic                              X_DONE,
    output logic                              X_ABORT,
    output logic                              BUSY
);
    import lnk_rq_pkg::*;

    localparam int RQI_W = SZ_RQCODE + 1;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [LW-1:0]       ptr;
    logic [LW-1:0]       lane;
    logic [SZ_RQCODE-1:0] code;
    logic [TMO_W-1:0]    cnt;
    xact_flags_t         flags;

    logic [NLANES-1:0]   elig;
    logic                pick_found;
    logic [LW-1:0]       pick_idx;
    logic                lane_req;
    logic                tmo_hit;

    always_comb begin
        elig = '0;
        for (int k = 0; k < NLANES; k++) begin
            elig[k] = M_REQUEST[k] & RQI_BUS[k*RQI_W];
        end
    end

    lnk_rr_pick #(
        .NLANES (NLANES),
        .LW     (LW)
    ) u_pick (
        .eligible (elig),
        .pointer  (ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    assign lane_req = M_REQUEST[lane];
    assign tmo_hit  = (cnt == TMO_CYC - 1'b1);

    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_SRST) begin
            state <= AIDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AIDLE: begin
                if (pick_found) begin
                    state_nxt = AEXEC;
                end
            end
            AEXEC: begin
                // a lane that withdrew mid-execution gets no response pulse
                if (X_DONE || tmo_hit) begin
                    state_nxt = flags.withdrawn ? AREL : ARESP;
                end
            end
            ARESP: begin
                state_nxt = AREL;
            end
            AREL: begin
                if (!lane_req) begin
                    state_nxt = AIDLE;
                end
            end
            default: begin
                state_nxt = AIDLE;
            end
        endcase
    end

    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_SRST) begin
            ptr   <= LW'(NLANES - 1);
            lane  <= '0;
            code  <= '0;
            cnt   <= '0;
            flags <= '0;
        end else begin
            flags.abort <= 1'b0;
            case (state)
                AIDLE: begin
                    if (pick_found) begin
                        ptr   <= pick_idx;
                        lane  <= pick_idx;
                        code  <= RQI_BUS[int'(pick_idx)*RQI_W + 1 +: SZ_RQCODE];
                        cnt   <= '0;
                        flags <= '0;
                    end
                end
                AEXEC: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (!X_DONE && tmo_hit) begin
                        flags.err   <= 1'b1;
                        flags.abort <= 1'b1;
                    end
                    if (!X_DONE && !tmo_hit && !lane_req) begin
                        flags.withdrawn <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        M_GRANT = '0;
        RQR_BUS = '0;
        if (state inside {AEXEC, ARESP, AREL}) begin
            M_GRANT[lane] = 1'b1;
        end
        if (state == ARESP) begin
            RQR_BUS[2*int'(lane) + RQR_DONE] = 1'b1;
            RQR_BUS[2*int'(lane) + RQR_ERR]  = flags.err;
        end
        X_VALID = (state == AEXEC);
        X_CODE  = code;
        X_LANE  = lane;
        X_ABORT = flags.abort;
        BUSY    = state inside {AEXEC, ARESP, AREL};
    end

endmodule

// File: tb/tb_lnk_rq_arbiter.sv
// Bench for lnk_rq_arbiter: directed scenarios with literal expectations plus a randomized run,
// all cycles compared against a transaction-level reference model.
module tb_lnk_rq_arbiter;
    import lnk_rq_pkg::*;

    localparam int          NL  = 4;
    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  mreq;
    logic [23:0] rqi;
    logic        xdone;
    logic [3:0]  grant;
    logic [7:0]  rqr;
    logic        xvalid;
    logic [4:0]  xcode;
    logic [1:0]  xlane;
    logic        xabort;
    logic        busy;

    always #5 clk = ~clk;

    lnk_rq_arbiter #(
        .NLANES    (NL),
        .LW        (2),
        .SZ_RQCODE (5),
        .TMO_W     (16),
        .TMO_CYC   (TMO)
    ) dut (
        .CTRL_CLK  (clk),
        .CTRL_SRST (srst),
        .M_REQUEST (mreq),
        .RQI_BUS   (rqi),
        .M_GRANT   (grant),
        .RQR_BUS   (rqr),
        .X_VALID   (xvalid),
        .X_CODE    (xcode),
        .X_LANE    (xlane),
        .X_DONE    (xdone),
        .X_ABORT   (xabort),
        .BUSY      (busy)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, whether the executor still owns
    // the request, and which response (if any) is visible this cycle.
    int          m_g, m_ptr, m_age, m_xlane, m_k;
    logic        m_xv, m_wd, m_abort, na;
    logic [1:0]  m_rqr, nr;
    logic [4:0]  m_code;

    initial begin
        m_g = -1; m_ptr = NL - 1; m_age = 0; m_xlane = 0;
        m_xv = 0; m_wd = 0; m_abort = 0; m_rqr = 0; m_code = 0;
        forever begin
            @(posedge clk);
            if (srst) begin
                m_g = -1; m_ptr = NL - 1; m_age = 0; m_xlane = 0;
                m_xv = 0; m_wd = 0; m_abort = 0; m_rqr = 0; m_code = 0;
            end else begin
                nr = 2'b00;
                na = 1'b0;
                if (m_g < 0) begin
                    for (int i = 1; i <= NL; i++) begin
                        m_k = (m_ptr + i) % NL;
                        if (m_g < 0 && mreq[m_k] && rqi[m_k*6]) begin
                            m_g = m_k; m_ptr = m_k; m_xlane = m_k;
                            m_code = rqi[m_k*6+1 +: 5];
                            m_xv = 1; m_age = 0; m_wd = 0;
                        end
                    end
                end else if (m_xv) begin
                    if (xdone || m_age == int'(TMO) - 1) begin
                        m_xv = 0;
                        na = !xdone;
                        if (!m_wd) nr = xdone ? 2'b01 : 2'b11;
                    end else if (!mreq[m_g]) begin
                        m_wd = 1;
                    end
                    if (m_age < 65535) m_age++;
                end else if (m_rqr == 2'b00) begin
                    if (!mreq[m_g]) m_g = -1;
                end
                m_rqr   = nr;
                m_abort = na;
            end
        end
    end

    logic [3:0] exp_grant;
    logic [7:0] exp_rqr;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_grant = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
                exp_rqr   = (m_g >= 0) ? 8'({6'b0, m_rqr} << (2*m_g)) : 8'b0;
                chk("m_grant", 32'(grant), 32'(exp_grant));
                chk("rqr_bus", 32'(rqr), 32'(exp_rqr));
                chk("x_valid", 32'(xvalid), 32'(m_xv));
                chk("x_code", 32'(xcode), 32'(m_code));
                chk("x_lane", 32'(xlane), 32'(m_xlane));
                chk("x_abort", 32'(xabort), 32'(m_abort));
                chk("busy", 32'(busy), 32'(m_g >= 0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic req, input logic en, input logic [4:0] c);
        mreq[k] = req;
        rqi[k*6 +: 6] = {c, en};
    endtask

    int         fair_order[6] = '{0, 1, 3, 0, 1, 3};
    logic [4:0] fair_code[4]  = '{RQC_L2R, RQC_PCSRST0, RQC_LNKUP, RQC_L2D};
    logic [3:0] seen;

    initial begin
        srst = 1; mreq = 0; rqi = 0; xdone = 0; seen = 0;
        step(); step();
        chk_en = 1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_xvalid", 32'(xvalid), 32'h0);
        srst = 0;

        // single request on lane 2
        set_lane(2, 1, 1, RQC_L2D);
        step();
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_code", 32'(xcode), 32'(RQC_L2D));
        chk("single_lane", 32'(xlane), 32'd2);
        chk("model_lane", 32'(m_g), 32'd2);
        set_lane(2, 1, 1, RQC_EQTRAIN);
        repeat (4) step();
        chk("code_latched", 32'(xcode), 32'(RQC_L2D));
        xdone = 1;
        step();
        chk("single_rqr", 32'(rqr), 32'h10);
        chk("single_xvalid_drop", 32'(xvalid), 32'h0);
        xdone = 0;
        step();
        chk("single_rqr_clear", 32'(rqr), 32'h0);
        chk("single_hold", 32'(grant), 32'b0100);
        step();
        chk("single_hold2", 32'(grant), 32'b0100);
        set_lane(2, 0, 1, RQC_L2D);
        step();
        chk("single_release", 32'(grant), 32'h0);
        chk("single_idle", 32'(busy), 32'h0);

        // timeout with no X_DONE
        set_lane(2, 1, 1, RQC_PCSRST0);
        step();
        chk("tmo_code", 32'(xcode), 32'(RQC_PCSRST0));
        repeat (15) step();
        chk("tmo_before", 32'(xabort), 32'h0);
        chk("tmo_before_valid", 32'(xvalid), 32'h1);
        step();
        chk("tmo_abort", 32'(xabort), 32'h1);
        chk("tmo_rqr", 32'(rqr), 32'h30);
        chk("tmo_xvalid", 32'(xvalid), 32'h0);
        chk("model_abort", 32'(m_abort), 32'h1);
        step();
        chk("tmo_abort_pulse", 32'(xabort), 32'h0);
        chk("tmo_rqr_clear", 32'(rqr), 32'h0);
        set_lane(2, 0, 1, RQC_PCSRST0);
        step(); step();

        // X_DONE on the expiry cycle counts as success
        set_lane(2, 1, 1, RQC_L2R);
        step();
        repeat (15) step();
        xdone = 1;
        step();
        chk("edge_rqr", 32'(rqr), 32'h10);
        chk("edge_abort", 32'(xabort), 32'h0);
        xdone = 0;
        set_lane(2, 0, 1, RQC_L2R);
        step(); step(); step();

        // early withdrawal by lane 1
        set_lane(1, 1, 1, RQC_L2D);
        step();
        chk("wd_lane", 32'(xlane), 32'd1);
        step(); step();
        set_lane(1, 0, 1, RQC_L2D);
        step();
        chk("wd_valid1", 32'(xvalid), 32'h1);
        step();
        chk("wd_valid2", 32'(xvalid), 32'h1);
        xdone = 1;
        step();
        chk("wd_valid_drop", 32'(xvalid), 32'h0);
        chk("wd_no_rqr", 32'(rqr), 32'h0);
        chk("wd_busy", 32'(busy), 32'h1);
        xdone = 0;
        step();
        chk("wd_idle", 32'(busy), 32'h0);
        chk("wd_grant", 32'(grant), 32'h0);

        // fairness across lanes 0,1,3 after reset
        srst = 1;
        step();
        srst = 0;
        set_lane(0, 1, 1, fair_code[0]);
        set_lane(1, 1, 1, fair_code[1]);
        set_lane(3, 1, 1, fair_code[3]);
        for (int n = 0; n < 6; n++) begin
            step();
            chk("fair_lane", 32'(xlane), 32'(fair_order[n]));
            chk("fair_code", 32'(xcode), 32'(fair_code[fair_order[n]]));
            step(); step();
            xdone = 1;
            step();
            xdone = 0;
            set_lane(fair_order[n], 0, 1, fair_code[fair_order[n]]);
            step(); step();
            set_lane(fair_order[n], 1, 1, fair_code[fair_order[n]]);
        end

        // reset in the middle of execution
        step();
        chk("rst_mid_lane_pre", 32'(xlane), 32'd0);
        step();
        srst = 1;
        step();
        chk("rstm_grant", 32'(grant), 32'h0);
        chk("rstm_rqr", 32'(rqr), 32'h0);
        chk("rstm_xvalid", 32'(xvalid), 32'h0);
        chk("rstm_code", 32'(xcode), 32'h0);
        chk("rstm_lane", 32'(xlane), 32'h0);
        chk("rstm_abort", 32'(xabort), 32'h0);
        chk("rstm_busy", 32'(busy), 32'h0);
        srst = 0;
        step();
        chk("rstm_prio", 32'(grant), 32'b0001);
        mreq = 0;
        xdone = 1;
        step();
        xdone = 0;
        step(); step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            srst  = ($urandom_range(0, 399) == 0);
            xdone = ($urandom_range(0, ((c / 500) % 2 == 1) ? 24 : 4) == 0);
            for (int k = 0; k < NL; k++) begin
                if (grant[k]) begin
                    if (rqr[2*k]) seen[k] = 1'b1;
                    if (seen[k] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0))
                        mreq[k] = 1'b0;
                    if ($urandom_range(0, 7) == 0)
                        rqi[k*6+1 +: 5] = 5'($urandom);
                end else begin
                    seen[k] = 1'b0;
                    if (!mreq[k]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            mreq[k] = 1'b1;
                            rqi[k*6 +: 6] = {5'($urandom), ($urandom_range(0, 7) != 0)};
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        mreq[k] = 1'b0;
                    end
                end
            end
        end
        srst = 0;
        step();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
